// File: rtl/riscv_ram_burst_loader.sv
// riscv_ram_burst_loader
// Accepts host AXI4 write bursts, checks each one against the core RAM window,
// and replays the accepted beats as single-beat aw/w transfers on the core RAM
// load port. The loader returns one B response per burst.
// Optional statistics counters (beat_cnt, err_cnt) are built only when the
// macro RAM_LOADER_STATS_EN is defined. Otherwise both outputs are tied to zero.
module riscv_ram_burst_loader #(
    parameter int                     DATA_W      = 512,
    parameter int                     RAM_ADDR_W  = 15,
    parameter int                     HOST_ADDR_W = 64,
    parameter int                     ID_W        = 12,
    parameter int                     LEN_W       = 8,
    parameter logic [HOST_ADDR_W-1:0] BASE_ADDR   = {HOST_ADDR_W{1'b0}}
) (
    input  logic                   axi4_mm_clk,
    input  logic                   axi4_mm_rst,
    input  logic                   load_en,
    input  logic                   s_awvalid,
    output logic                   s_awready,
    input  logic [HOST_ADDR_W-1:0] s_awaddr,
    input  logic [ID_W-1:0]        s_awid,
    input  logic [LEN_W-1:0]       s_awlen,
    input  logic [2:0]             s_awsize,
    input  logic                   s_wvalid,
    output logic                   s_wready,
    input  logic [DATA_W-1:0]      s_wdata,
    input  logic [DATA_W/8-1:0]    s_wstrb,
    input  logic                   s_wlast,
    output logic                   s_bvalid,
    input  logic                   s_bready,
    output logic [ID_W-1:0]        s_bid,
    output logic [1:0]             s_bresp,
    output logic                   ram_aw_valid,
    input  logic                   ram_aw_ready,
    output logic [RAM_ADDR_W-1:0]  ram_aw_addr,
    output logic                   ram_w_valid,
    input  logic                   ram_w_ready,
    output logic [DATA_W-1:0]      ram_w_data,
    output logic [DATA_W/8-1:0]    ram_w_strb,
    output logic                   busy,
    output logic [31:0]            beat_cnt,
    output logic [15:0]            err_cnt
);

    localparam int BEAT_BYTES = DATA_W / 8;
    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam int STRB_W     = DATA_W / 8;
    localparam int CNT_W      = LEN_W + 1;
    localparam int BOUND_W    = RAM_ADDR_W + LEN_W + 1;

    localparam logic [1:0]            RESP_OKAY    = 2'b00;
    localparam logic [1:0]            RESP_SLVERR  = 2'b10;
    localparam logic [BOUND_W-1:0]    WINDOW_BYTES = BOUND_W'(1) << RAM_ADDR_W;
    localparam logic [RAM_ADDR_W-1:0] BEAT_STEP    = RAM_ADDR_W'(BEAT_BYTES);
    localparam logic [RAM_ADDR_W-1:0] ALIGN_MASK   = ~RAM_ADDR_W'(BEAT_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                  state_r;
    logic [ID_W-1:0]         id_r;
    logic [CNT_W-1:0]        remaining_r;   // beats still to be written to RAM
    logic [CNT_W-1:0]        w_left_r;      // beats still to be accepted from host
    logic [RAM_ADDR_W-1:0]   off_r;         // RAM offset of the buffered beat
    logic                    err_r;
    logic                    bad_last_r;
    logic                    buf_valid_r;
    logic                    aw_done_r;
    logic                    w_done_r;
    logic                    s_awready_r;
    logic                    s_bvalid_r;
    logic [ID_W-1:0]         s_bid_r;
    logic [1:0]              s_bresp_r;
    logic                    ram_aw_valid_r;
    logic [RAM_ADDR_W-1:0]   ram_aw_addr_r;
    logic                    ram_w_valid_r;
    logic [DATA_W-1:0]       ram_w_data_r;
    logic [STRB_W-1:0]       ram_w_strb_r;
    logic                    busy_r;

    logic [HOST_ADDR_W-1:0]  rel_addr_s;
    logic [RAM_ADDR_W-1:0]   start_off_s;
    logic [BOUND_W-1:0]      end_bound_s;
    logic                    below_base_s;
    logic                    addr_hi_s;
    logic                    aw_err_s;
    logic                    aw_fire_s;
    logic                    ram_aw_fire_s;
    logic                    ram_w_fire_s;
    logic                    beat_done_s;
    logic                    s_wready_s;
    logic                    w_fire_s;
    logic                    last_exp_s;

    // Window check for the incoming burst, evaluated every cycle and used on AW acceptance.
    always_comb begin
        rel_addr_s   = s_awaddr - BASE_ADDR;
        below_base_s = (s_awaddr < BASE_ADDR);
        start_off_s  = rel_addr_s[RAM_ADDR_W-1:0] & ALIGN_MASK;
        addr_hi_s    = |rel_addr_s[HOST_ADDR_W-1:RAM_ADDR_W];
        end_bound_s  = BOUND_W'(start_off_s)
                     + ((BOUND_W'(s_awlen) + BOUND_W'(1)) << BEAT_SHIFT);
        aw_err_s     = !load_en
                     || (s_awsize != 3'(BEAT_SHIFT))
                     || below_base_s
                     || addr_hi_s
                     || (end_bound_s > WINDOW_BYTES);
    end

    // Handshake decode, beat completion and host write-ready generation.
    always_comb begin
        aw_fire_s     = s_awvalid && s_awready_r;
        ram_aw_fire_s = ram_aw_valid_r && ram_aw_ready;
        ram_w_fire_s  = ram_w_valid_r && ram_w_ready;
        beat_done_s   = (state_r == ST_DATA) && buf_valid_r
                     && (aw_done_r || ram_aw_fire_s)
                     && (w_done_r || ram_w_fire_s);
        last_exp_s    = (w_left_r == CNT_W'(1));
        case (state_r)
            ST_DATA:  s_wready_s = (w_left_r != CNT_W'(0)) && (!buf_valid_r || beat_done_s);
            ST_DRAIN: s_wready_s = 1'b1;
            default:  s_wready_s = 1'b0;
        endcase
        w_fire_s = s_wvalid && s_wready_s;
    end

    // Burst FSM: AW capture, single-entry beat buffer, drain of rejected bursts, and B response.
    always_ff @(posedge axi4_mm_clk) begin
        if (axi4_mm_rst) begin
            state_r        <= ST_IDLE;
            id_r           <= {ID_W{1'b0}};
            remaining_r    <= {CNT_W{1'b0}};
            w_left_r       <= {CNT_W{1'b0}};
            off_r          <= {RAM_ADDR_W{1'b0}};
            err_r          <= 1'b0;
            bad_last_r     <= 1'b0;
            buf_valid_r    <= 1'b0;
            aw_done_r      <= 1'b0;
            w_done_r       <= 1'b0;
            s_awready_r    <= 1'b1;
            s_bvalid_r     <= 1'b0;
            s_bid_r        <= {ID_W{1'b0}};
            s_bresp_r      <= RESP_OKAY;
            ram_aw_valid_r <= 1'b0;
            ram_aw_addr_r  <= {RAM_ADDR_W{1'b0}};
            ram_w_valid_r  <= 1'b0;
            ram_w_data_r   <= {DATA_W{1'b0}};
            ram_w_strb_r   <= {STRB_W{1'b0}};
            busy_r         <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (aw_fire_s) begin
                        id_r        <= s_awid;
                        remaining_r <= CNT_W'(s_awlen) + CNT_W'(1);
                        w_left_r    <= CNT_W'(s_awlen) + CNT_W'(1);
                        off_r       <= start_off_s;
                        err_r       <= aw_err_s;
                        bad_last_r  <= 1'b0;
                        buf_valid_r <= 1'b0;
                        aw_done_r   <= 1'b0;
                        w_done_r    <= 1'b0;
                        s_awready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        state_r     <= aw_err_s ? ST_DRAIN : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_fire_s) begin
                        w_left_r <= w_left_r - CNT_W'(1);
                        if (s_wlast != last_exp_s) begin
                            bad_last_r <= 1'b1;
                        end
                    end
                    if (beat_done_s) begin
                        off_r       <= off_r + BEAT_STEP;
                        remaining_r <= remaining_r - CNT_W'(1);
                        aw_done_r   <= 1'b0;
                        w_done_r    <= 1'b0;
                        if (w_fire_s) begin
                            buf_valid_r    <= 1'b1;
                            ram_aw_valid_r <= 1'b1;
                            ram_w_valid_r  <= 1'b1;
                            ram_aw_addr_r  <= off_r + BEAT_STEP;
                            ram_w_data_r   <= s_wdata;
                            ram_w_strb_r   <= s_wstrb;
                        end else begin
                            buf_valid_r    <= 1'b0;
                            ram_aw_valid_r <= 1'b0;
                            ram_w_valid_r  <= 1'b0;
                        end
                        if (remaining_r == CNT_W'(1)) begin
                            state_r    <= ST_RESP;
                            s_bvalid_r <= 1'b1;
                            s_bid_r    <= id_r;
                            s_bresp_r  <= (err_r || bad_last_r) ? RESP_SLVERR : RESP_OKAY;
                        end
                    end else begin
                        if (ram_aw_fire_s) begin
                            ram_aw_valid_r <= 1'b0;
                            aw_done_r      <= 1'b1;
                        end
                        if (ram_w_fire_s) begin
                            ram_w_valid_r <= 1'b0;
                            w_done_r      <= 1'b1;
                        end
                        if (w_fire_s) begin
                            buf_valid_r    <= 1'b1;
                            ram_aw_valid_r <= 1'b1;
                            ram_w_valid_r  <= 1'b1;
                            ram_aw_addr_r  <= off_r;
                            ram_w_data_r   <= s_wdata;
                            ram_w_strb_r   <= s_wstrb;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_fire_s) begin
                        w_left_r <= w_left_r - CNT_W'(1);
                        if (w_left_r == CNT_W'(1)) begin
                            state_r    <= ST_RESP;
                            s_bvalid_r <= 1'b1;
                            s_bid_r    <= id_r;
                            s_bresp_r  <= RESP_SLVERR;
                        end
                    end
                end
                ST_RESP: begin
                    if (s_bready) begin
                        s_bvalid_r  <= 1'b0;
                        s_awready_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    s_awready_r <= 1'b1;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

`ifdef RAM_LOADER_STATS_EN
    logic [31:0] beat_cnt_r;
    logic [15:0] err_cnt_r;

    // Statistics: beats written to RAM (wrapping) and SLVERR responses (saturating).
    always_ff @(posedge axi4_mm_clk) begin
        if (axi4_mm_rst) begin
            beat_cnt_r <= 32'd0;
            err_cnt_r  <= 16'd0;
        end else begin
            if (beat_done_s) begin
                beat_cnt_r <= beat_cnt_r + 32'd1;
            end
            if (s_bvalid_r && s_bready && (s_bresp_r == RESP_SLVERR)
                && (err_cnt_r != 16'hFFFF)) begin
                err_cnt_r <= err_cnt_r + 16'd1;
            end
        end
    end

    assign beat_cnt = beat_cnt_r;
    assign err_cnt  = err_cnt_r;
`else
    assign beat_cnt = 32'd0;
    assign err_cnt  = 16'd0;
`endif

    assign s_awready    = s_awready_r;
    assign s_wready     = s_wready_s;
    assign s_bvalid     = s_bvalid_r;
    assign s_bid        = s_bid_r;
    assign s_bresp      = s_bresp_r;
    assign ram_aw_valid = ram_aw_valid_r;
    assign ram_aw_addr  = ram_aw_addr_r;
    assign ram_w_valid  = ram_w_valid_r;
    assign ram_w_data   = ram_w_data_r;
    assign ram_w_strb   = ram_w_strb_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_riscv_ram_burst_loader.sv
// Directed testbench for riscv_ram_burst_loader with default parameters.
// Expected RAM beats and B responses are queued when the host side is driven.
// They are compared when the DUT presents the matching handshake.
module tb_riscv_ram_burst_loader;

    logic         clk = 1'b0;
    logic         axi4_mm_rst;
    logic         load_en;
    logic         s_awvalid;
    logic         s_awready;
    logic [63:0]  s_awaddr;
    logic [11:0]  s_awid;
    logic [7:0]   s_awlen;
    logic [2:0]   s_awsize;
    logic         s_wvalid;
    logic         s_wready;
    logic [511:0] s_wdata;
    logic [63:0]  s_wstrb;
    logic         s_wlast;
    logic         s_bvalid;
    logic         s_bready;
    logic [11:0]  s_bid;
    logic [1:0]   s_bresp;
    logic         ram_aw_valid;
    logic         ram_aw_ready;
    logic [14:0]  ram_aw_addr;
    logic         ram_w_valid;
    logic         ram_w_ready;
    logic [511:0] ram_w_data;
    logic [63:0]  ram_w_strb;
    logic         busy;
    logic [31:0]  beat_cnt;
    logic [15:0]  err_cnt;

    riscv_ram_burst_loader dut (
        .axi4_mm_clk  (clk),
        .axi4_mm_rst  (axi4_mm_rst),
        .load_en      (load_en),
        .s_awvalid    (s_awvalid),
        .s_awready    (s_awready),
        .s_awaddr     (s_awaddr),
        .s_awid       (s_awid),
        .s_awlen      (s_awlen),
        .s_awsize     (s_awsize),
        .s_wvalid     (s_wvalid),
        .s_wready     (s_wready),
        .s_wdata      (s_wdata),
        .s_wstrb      (s_wstrb),
        .s_wlast      (s_wlast),
        .s_bvalid     (s_bvalid),
        .s_bready     (s_bready),
        .s_bid        (s_bid),
        .s_bresp      (s_bresp),
        .ram_aw_valid (ram_aw_valid),
        .ram_aw_ready (ram_aw_ready),
        .ram_aw_addr  (ram_aw_addr),
        .ram_w_valid  (ram_w_valid),
        .ram_w_ready  (ram_w_ready),
        .ram_w_data   (ram_w_data),
        .ram_w_strb   (ram_w_strb),
        .busy         (busy),
        .beat_cnt     (beat_cnt),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [14:0]  exp_aw_q[$];
    logic [575:0] exp_w_q[$];
    logic [13:0]  exp_b_q[$];
    logic [14:0]  exp_addr;
    int           exp_beats;
    int           exp_errs;
    logic         expect_ram;
    logic         in_err_burst;
    logic         bp_mode;
    int           bp_cnt;
    logic         aw_hs_seen;
    logic         w_hs_seen;
    logic         b_hs_seen;

    task automatic chk(input string tag, input logic [639:0] got, input logic [639:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_true(input string tag, input logic cond);
        checks++;
        assert (cond) else begin
            errors++;
            $error("FAIL %s: observed=0 expected=1", tag);
        end
    endtask

    // One clock: sample handshakes at the falling edge, then advance past the rising edge.
    task automatic tick();
        logic [575:0] we;
        logic [13:0]  be;
        aw_hs_seen = 1'b0;
        w_hs_seen  = 1'b0;
        b_hs_seen  = 1'b0;
        @(negedge clk);
        if (s_awvalid && s_awready) aw_hs_seen = 1'b1;
        if (s_wvalid && s_wready) begin
            w_hs_seen = 1'b1;
            if (expect_ram) begin
                exp_aw_q.push_back(exp_addr);
                exp_w_q.push_back({s_wstrb, s_wdata});
                exp_addr = exp_addr + 15'h40;
            end
        end
        if (in_err_burst) chk("no_ram_valid", 640'({ram_aw_valid, ram_w_valid}), 640'(2'b00));
        if (bp_mode && ram_w_valid && !ram_w_ready) chk("wready_held_low", 640'(s_wready), 640'(1'b0));
        if (ram_aw_valid && ram_aw_ready) begin
            chk_true("ram_aw_expected", exp_aw_q.size() != 0);
            if (exp_aw_q.size() != 0) chk("ram_aw_addr", 640'(ram_aw_addr), 640'(exp_aw_q.pop_front()));
        end
        if (ram_w_valid && ram_w_ready) begin
            chk_true("ram_w_expected", exp_w_q.size() != 0);
            if (exp_w_q.size() != 0) begin
                we = exp_w_q.pop_front();
                chk("ram_w_data", 640'(ram_w_data), 640'(we[511:0]));
                chk("ram_w_strb", 640'(ram_w_strb), 640'(we[575:512]));
                exp_beats++;
            end
        end
        if (s_bvalid && s_bready) begin
            b_hs_seen = 1'b1;
            chk_true("b_expected", exp_b_q.size() != 0);
            if (exp_b_q.size() != 0) begin
                be = exp_b_q.pop_front();
                chk("s_bid", 640'(s_bid), 640'(be[13:2]));
                chk("s_bresp", 640'(s_bresp), 640'(be[1:0]));
                if (be[1:0] == 2'b10) exp_errs++;
            end
        end
        @(posedge clk);
        #1;
        if (bp_mode) begin
            if (ram_w_valid) begin
                ram_w_ready = (bp_cnt == 3);
                bp_cnt      = (bp_cnt == 3) ? 0 : bp_cnt + 1;
            end else begin
                ram_w_ready = 1'b0;
                bp_cnt      = 0;
            end
        end
    endtask

    task automatic do_aw(input logic [63:0] addr, input logic [11:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic le);
        s_awvalid = 1'b1;
        s_awaddr  = addr;
        s_awid    = id;
        s_awlen   = len;
        s_awsize  = size;
        load_en   = le;
        exp_addr  = addr[14:0] & 15'h7FC0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (aw_hs_seen) break;
        end
        chk_true("aw_accept_timeout", aw_hs_seen);
        s_awvalid = 1'b0;
    endtask

    task automatic do_beat(input logic last);
        s_wvalid = 1'b1;
        for (int k = 0; k < 16; k++) s_wdata[k*32 +: 32] = $urandom;
        s_wstrb = {$urandom, $urandom};
        s_wlast = last;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (w_hs_seen) break;
        end
        chk_true("w_accept_timeout", w_hs_seen);
    endtask

    task automatic wait_b();
        for (int k = 0; k < 200; k++) begin
            tick();
            if (b_hs_seen) break;
        end
        chk_true("b_timeout", b_hs_seen);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_drained"}, 640'({exp_aw_q.size() == 0, exp_w_q.size() == 0, exp_b_q.size() == 0}), 640'(3'b111));
        chk({tag, "_awready"}, 640'(s_awready), 640'(1'b1));
        chk({tag, "_busy"}, 640'(busy), 640'(1'b0));
`ifdef RAM_LOADER_STATS_EN
        chk({tag, "_beat_cnt"}, 640'(beat_cnt), 640'(exp_beats));
        chk({tag, "_err_cnt"}, 640'(err_cnt), 640'(exp_errs));
`else
        chk({tag, "_beat_cnt"}, 640'(beat_cnt), 640'(32'd0));
        chk({tag, "_err_cnt"}, 640'(err_cnt), 640'(16'd0));
`endif
    endtask

    task automatic run_burst(input string tag, input logic [63:0] addr, input logic [11:0] id,
                             input logic [7:0] len, input logic [2:0] size, input logic le,
                             input logic le_after, input int last_idx, input logic [1:0] resp,
                             input logic to_ram);
        expect_ram   = to_ram;
        in_err_burst = !to_ram;
        exp_b_q.push_back({id, resp});
        do_aw(addr, id, len, size, le);
        chk({tag, "_busy_active"}, 640'(busy), 640'(1'b1));
        load_en = le_after;
        for (int i = 0; i <= int'(len); i++) do_beat(i == last_idx);
        s_wvalid = 1'b0;
        s_wlast  = 1'b0;
        wait_b();
        in_err_burst = 1'b0;
        load_en      = 1'b1;
        check_idle(tag);
    endtask

    initial begin
        axi4_mm_rst  = 1'b1;
        load_en      = 1'b1;
        s_awvalid    = 1'b0;
        s_awaddr     = 64'h0;
        s_awid       = 12'h0;
        s_awlen      = 8'h0;
        s_awsize     = 3'd6;
        s_wvalid     = 1'b0;
        s_wdata      = 512'h0;
        s_wstrb      = 64'h0;
        s_wlast      = 1'b0;
        s_bready     = 1'b1;
        ram_aw_ready = 1'b1;
        ram_w_ready  = 1'b1;
        exp_addr     = 15'h0;
        exp_beats    = 0;
        exp_errs     = 0;
        expect_ram   = 1'b1;
        in_err_burst = 1'b0;
        bp_mode      = 1'b0;
        bp_cnt       = 0;
        repeat (3) tick();
        axi4_mm_rst = 1'b0;

        // reset state
        chk("rst_awready", 640'(s_awready), 640'(1'b1));
        chk("rst_valids", 640'({s_wready, s_bvalid, ram_aw_valid, ram_w_valid, busy}), 640'(5'b00000));
        chk("rst_payloads", 640'({s_bid, s_bresp, ram_aw_addr}), 640'(29'd0));
        chk("rst_ram_data", 640'({ram_w_strb, ram_w_data}), 640'(576'd0));
        chk("rst_counters", 640'({beat_cnt, err_cnt}), 640'(48'd0));
        tick();

        // 4-beat burst at 0x100
        run_burst("burst4", 64'h100, 12'h123, 8'd3, 3'd6, 1'b1, 1'b1, 3, 2'b00, 1'b1);

        // ram_w_ready backpressure, aw free-running
        bp_mode = 1'b1;
        run_burst("backpressure", 64'h400, 12'h045, 8'd1, 3'd6, 1'b1, 1'b1, 1, 2'b00, 1'b1);
        bp_mode     = 1'b0;
        ram_w_ready = 1'b1;

        // window overflow and exact-fit boundary
        run_burst("overflow", 64'h7FC0, 12'h0AA, 8'd1, 3'd6, 1'b1, 1'b1, 1, 2'b10, 1'b0);
        run_burst("exact_fit", 64'h7F80, 12'h0AB, 8'd1, 3'd6, 1'b1, 1'b1, 1, 2'b00, 1'b1);

        // rejected by load_en and by size
        run_burst("load_en_off", 64'h200, 12'h0B1, 8'd2, 3'd6, 1'b0, 1'b0, 2, 2'b10, 1'b0);
        run_burst("bad_size", 64'h200, 12'h0B2, 8'd1, 3'd5, 1'b1, 1'b1, 1, 2'b10, 1'b0);

        // load_en dropped after AW acceptance
        run_burst("load_en_drop", 64'h600, 12'h0C3, 8'd2, 3'd6, 1'b1, 1'b0, 2, 2'b00, 1'b1);

        // wlast asserted early on beat 2 of 4
        run_burst("early_wlast", 64'h1000, 12'hFED, 8'd3, 3'd6, 1'b1, 1'b1, 1, 2'b10, 1'b1);

        // reset pulse while beat 2 of 4 is in flight
        expect_ram = 1'b1;
        do_aw(64'h2000, 12'h777, 8'd3, 3'd6, 1'b1);
        do_beat(1'b0);
        do_beat(1'b0);
        s_wvalid    = 1'b0;
        axi4_mm_rst = 1'b1;
        tick();
        chk("midrst_valids", 640'({ram_aw_valid, ram_w_valid, s_bvalid, busy}), 640'(4'b0000));
        chk("midrst_awready", 640'(s_awready), 640'(1'b1));
        axi4_mm_rst = 1'b0;
        exp_aw_q.delete();
        exp_w_q.delete();
        exp_beats = 0;
        exp_errs  = 0;
        repeat (3) tick();
        check_idle("after_rst");
        run_burst("post_rst", 64'h3040, 12'h321, 8'd2, 3'd6, 1'b1, 1'b1, 2, 2'b00, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_ram_burst_loader.md
Name: riscv_ram_burst_loader

Overview:
Parametrised successor to the single-beat host program-load path into the RISC-V core RAM. Accepts full AXI4 write bursts from the host (len > 0) and checks each burst against a RAM address window. Splits each burst into single-beat aw/w transactions on the core RAM load port, with incrementing addresses, and returns one B response per burst. Sits between the host AXI-MM write channels and the core's io_in_ram_io write port.

Parameters:
DATA_W, 512, data beat width in bits (power of 2, >=32); BEAT_BYTES = DATA_W/8
RAM_ADDR_W, 15, core RAM byte-address width; window size = 2^RAM_ADDR_W bytes
HOST_ADDR_W, 64, host address width
ID_W, 12, AXI ID width
LEN_W, 8, host burst length field width (beats = len+1)
BASE_ADDR, 64'h0, host byte address mapped to RAM offset 0

Ports:
axi4_mm_clk  in  1  clock
axi4_mm_rst  in  1  synchronous active-high reset
load_en  in  1  program-load enable, sampled at AW acceptance
s_awvalid/s_awready  in/out  1/1  host write-address handshake
s_awaddr  in  HOST_ADDR_W  burst start byte address
s_awid  in  ID_W  burst ID
s_awlen  in  LEN_W  beats-1
s_awsize  in  3  must equal log2(BEAT_BYTES)
s_wvalid/s_wready  in/out  1/1  host write-data handshake
s_wdata  in  DATA_W  beat data
s_wstrb  in  DATA_W/8  byte strobes
s_wlast  in  1  last beat flag
s_bvalid/s_bready  out/in  1/1  write-response handshake
s_bid  out  ID_W  echoed burst ID
s_bresp  out  2  2'b00 OKAY, 2'b10 SLVERR
ram_aw_valid/ram_aw_ready  out/in  1/1  core RAM address handshake
ram_aw_addr  out  RAM_ADDR_W  beat byte address, BEAT_BYTES-aligned
ram_w_valid/ram_w_ready  out/in  1/1  core RAM data handshake
ram_w_data  out  DATA_W  beat data
ram_w_strb  out  DATA_W/8  beat strobes
busy  out  1  high in any state other than IDLE
beat_cnt  out  32  RAM beats written (optional feature)
err_cnt  out  16  SLVERR bursts (optional feature)

Behaviour:
- Reset: state IDLE; s_awready=1; s_wready, s_bvalid, ram_aw_valid, ram_w_valid, busy = 0; s_bid, s_bresp, ram_* payloads, beat_cnt, err_cnt = 0. Reset mid-burst aborts it immediately; no B is issued.
- FSM states: IDLE, DATA, DRAIN, RESP.
- IDLE: s_awready=1. On AW handshake, capture id and len; set off = (s_awaddr - BASE_ADDR) with the low log2(BEAT_BYTES) bits cleared; set remaining = len+1.
  - Error if any of: load_en=0; s_awsize != log2(BEAT_BYTES); s_awaddr < BASE_ADDR; off + (len+1)*BEAT_BYTES > 2^RAM_ADDR_W. Compute the bound in RAM_ADDR_W+LEN_W+1 bits so it cannot overflow.
  - Error -> DRAIN. Otherwise -> DATA.
- DATA: single-entry beat buffer.
  - s_wready = !buf_valid || beat_done, where beat_done = both the RAM aw and RAM w handshakes complete, in this cycle or earlier.
  - A host W handshake loads the buffer; ram_aw_valid and ram_w_valid assert the next cycle, both together.
  - aw and w complete independently. A per-channel done flag drops that channel's valid once its handshake occurs.
  - On beat_done: off += BEAT_BYTES, remaining -= 1, done flags clear.
  - Throughput is 1 beat/cycle with both RAM readys high. First RAM valid appears 1 cycle after the first W handshake.
  - After the final beat_done -> RESP.
  - s_wlast must be 1 on exactly beat len+1. A mismatch sets the sticky bad_last flag. The beat count always follows len, not wlast.
- DRAIN: s_wready=1. Consume exactly len+1 beats with no RAM traffic, then -> RESP with SLVERR.
- RESP: s_bvalid=1, s_bid = captured id, s_bresp = SLVERR if (error || bad_last), else OKAY. Hold until s_bready, then -> IDLE.
- load_en falling mid-burst has no effect; it is only latched at AW acceptance.
- s_awready=0 outside IDLE, so only one burst is outstanding.
- Valids never drop without a handshake, and payloads stay stable while valid.

Optional Feature:
RAM_LOADER_STATS_EN
- Defined:
  - beat_cnt increments on each beat_done and wraps at 2^32.
  - err_cnt increments on each SLVERR B handshake and saturates at 16'hFFFF.
  - Both clear on reset.
- Undefined: beat_cnt and err_cnt are tied to 0 and no counter logic is generated.

Test Plan:
- Burst of 4 beats: BASE_ADDR=0, awaddr=0x100, len=3, size=6, load_en=1, RAM readys high. Expected: ram_aw_addr 0x100, 0x140, 0x180, 0x1C0, data in order; one B OKAY with the captured id; beat_cnt=4.
- Backpressure: ram_aw_ready high while ram_w_ready is held low for 3 cycles per beat, len=1. Expected: aw handshakes once per beat, w waits, no duplicate aw; s_wready stays low until beat_done; B OKAY.
- Window overflow: awaddr=0x7FC0, len=1 (end 0x8040 > 0x8000). Expected: no RAM valids; 2 W beats accepted; B SLVERR; err_cnt=1.
- load_en=0 or size=5. Expected: DRAIN behaviour and SLVERR. Also: load_en dropped after AW acceptance still completes the burst with OKAY.
- Early wlast on beat 2 of len=3. Expected: all 4 beats written to RAM; B SLVERR.
- Reset pulse during the DATA beat 2 of 4. Expected: next cycle all valids 0, s_awready=1, busy=0; a new burst then completes normally.
